// File: rtl/sparc_ctrl_seq.sv
// Moore control sequencer for the SPARC datapath: fetch/decode/execute, Bicc, Ticc and trap entry.
// Optional MFC watchdog in F2 is enabled by defining SPARC_CTRL_MFC_TIMEOUT_EN.
module sparc_ctrl_seq #(
  parameter int MFC_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] IR,
  input  logic        MFC,
  input  logic [3:0]  ICC,
  input  logic        ET,
  input  logic        TRAP_REQ,
  output logic        IRE, MDRE, MARE, PCE, nPCE, RFE, TBRE, PSRE, WIME, tQE,
  output logic        ClrPC, nPCClr, IRClr, tQClr,
  output logic        ALUE, MFA, nPC_ADD, nPC_ADDSEL, BAUX, MOP_SEL, PSR_SEL, RA_SEL, DISP_SEL, AOP_SEL,
  output logic [1:0]  nPC_SEL, MAR_SEL, MDR_SEL, ALU_SEL, CIN_SEL, RC_SEL,
  output logic [5:0]  OP1,
  output logic        ERR,
  output logic [4:0]  STATE
);

  typedef enum logic [4:0] {
    S_RST1 = 5'd0,  S_RST2 = 5'd1,  S_RST3 = 5'd2,  S_F1  = 5'd3,
    S_F2   = 5'd4,  S_F3   = 5'd5,  S_DEC  = 5'd6,  S_ALU = 5'd7,
    S_N1   = 5'd8,  S_N2   = 5'd9,  S_BR   = 5'd10, S_BT1 = 5'd11,
    S_BT2  = 5'd12, S_TRAP = 5'd13, S_T1   = 5'd14, S_T2  = 5'd15,
    S_T3   = 5'd16, S_T4   = 5'd17, S_T5   = 5'd18, S_T6  = 5'd19,
    S_ERR  = 5'd31
  } state_t;

  state_t state, state_nxt;
  logic   annul, annul_nxt;
  logic   trap_true, trap_true_nxt;
  logic   is_ticc, is_bicc, is_fmt3, cond_true;
  logic   unused_bits;

  // SPARC V8 icc condition table; bit 3 of the field inverts the base test.
  function automatic logic icc_cond(input logic [3:0] c, input logic [3:0] icc);
    logic n, z, v, cy, base;
    {n, z, v, cy} = icc;
    case (c[2:0])
      3'b000:  base = 1'b0;
      3'b001:  base = z;
      3'b010:  base = z | (n ^ v);
      3'b011:  base = n ^ v;
      3'b100:  base = cy | z;
      3'b101:  base = cy;
      3'b110:  base = n;
      default: base = v;
    endcase
    return c[3] ^ base;
  endfunction

  assign is_ticc     = (IR[31:30] == 2'b10) && (IR[24:19] == 6'h3A);
  assign is_bicc     = (IR[31:30] == 2'b00) && (IR[24:22] == 3'b010);
  assign is_fmt3     = (IR[31:30] == 2'b10);
  assign cond_true   = icc_cond(IR[28:25], ICC);
  assign unused_bits = ^{IR[18:0], MFC_TIMEOUT[0]};

`ifdef SPARC_CTRL_MFC_TIMEOUT_EN
  localparam int CW = ($clog2(MFC_TIMEOUT + 1) > 4) ? $clog2(MFC_TIMEOUT + 1) : 4;
  logic [CW-1:0] mfc_cnt;
  logic          mfc_expired;

  // Counts cycles already spent in F2; zero on every F2 entry.
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr)              mfc_cnt <= '0;
    else if (state == S_F2) mfc_cnt <= mfc_cnt + 1'b1;
    else                   mfc_cnt <= '0;
  end
  assign mfc_expired = (mfc_cnt == CW'(MFC_TIMEOUT - 1));
`else
  logic mfc_expired;
  assign mfc_expired = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state     <= S_RST1;
      annul     <= 1'b0;
      trap_true <= 1'b0;
    end else begin
      state     <= state_nxt;
      annul     <= annul_nxt;
      trap_true <= trap_true_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    annul_nxt     = annul;
    trap_true_nxt = trap_true;
    case (state)
      S_RST1: state_nxt = S_RST2;
      S_RST2: state_nxt = S_RST3;
      S_RST3: state_nxt = S_F1;
      S_F1:   state_nxt = S_F2;
      S_F2: begin
        if (MFC)              state_nxt = S_F3;
        else if (mfc_expired) state_nxt = S_ERR;
      end
      S_F3:   state_nxt = S_DEC;
      S_DEC: begin
        if (is_ticc) begin
          state_nxt     = S_TRAP;
          trap_true_nxt = cond_true;
        end else if (is_bicc) state_nxt = S_BR;
        else if (is_fmt3)     state_nxt = S_ALU;
        else                  state_nxt = S_N1;
      end
      S_ALU:  state_nxt = S_N1;
      S_N1:   state_nxt = S_N2;
      S_N2: begin
        // A trap flushes any pending annul of the delay slot.
        if (TRAP_REQ) begin
          state_nxt = ET ? S_T1 : S_ERR;
          annul_nxt = 1'b0;
        end else if (annul) begin
          state_nxt = S_N1;
          annul_nxt = 1'b0;
        end else state_nxt = S_F1;
      end
      S_BR: begin
        annul_nxt = IR[29] & (~cond_true | (IR[28:25] == 4'b1000));
        state_nxt = cond_true ? S_BT1 : S_N1;
      end
      S_BT1:  state_nxt = S_BT2;
      S_BT2: begin
        // Annulled taken branch skips the delay slot and fetches the target next.
        if (annul) begin
          state_nxt = S_N1;
          annul_nxt = 1'b0;
        end else state_nxt = S_F1;
      end
      S_TRAP: state_nxt = S_N1;
      S_T1:   state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3:   state_nxt = S_T4;
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = S_T6;
      S_T6:   state_nxt = S_F1;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase
  end

  always_comb begin
    {IRE, MDRE, MARE, PCE, nPCE, RFE, TBRE, PSRE, WIME, tQE} = 10'h3FF;
    {ClrPC, nPCClr, IRClr, tQClr} = 4'hF;
    {ALUE, MFA, nPC_ADD, nPC_ADDSEL, BAUX, MOP_SEL, PSR_SEL, RA_SEL, DISP_SEL, AOP_SEL} = 10'h000;
    {nPC_SEL, MAR_SEL, MDR_SEL, ALU_SEL, CIN_SEL, RC_SEL} = 12'h000;
    OP1   = 6'h08;
    ERR   = 1'b0;
    STATE = state;
    case (state)
      S_RST1: {ClrPC, nPCClr, IRClr, tQClr} = 4'h0;
      S_RST2: {TBRE, PSRE, WIME, RFE} = 4'h0;
      S_RST3: begin nPCE = 1'b0; nPC_ADD = 1'b1; end
      S_F1:   begin MARE = 1'b0; MAR_SEL = 2'd1; end
      S_F2:   begin MDRE = 1'b0; MFA = 1'b1; MOP_SEL = 1'b1; MDR_SEL = 2'd0; end
      S_F3:   IRE = 1'b0;
      S_ALU:  begin RFE = 1'b0; ALUE = 1'b1; CIN_SEL = 2'd2; end
      S_N1:   PCE = 1'b0;
      S_N2:   begin nPCE = 1'b0; nPC_ADD = 1'b1; end
      S_BT1:  PCE = 1'b0;
      S_BT2:  begin nPCE = 1'b0; BAUX = 1'b1; nPC_SEL = 2'd2; DISP_SEL = 1'b0; end
      S_TRAP: tQE = ~trap_true;
      S_T1:   begin PSRE = 1'b0; PSR_SEL = 1'b1; RFE = 1'b0; CIN_SEL = 2'd0; RC_SEL = 2'd2; end
      S_T2:   begin RFE = 1'b0; CIN_SEL = 2'd1; RC_SEL = 2'd1; end
      S_T3:   TBRE = 1'b0;
      S_T4:   begin nPCE = 1'b0; nPC_SEL = 2'd1; end
      S_T5:   PCE = 1'b0;
      S_T6:   begin nPCE = 1'b0; nPC_ADD = 1'b1; end
      S_ERR:  ERR = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sparc_ctrl_seq.sv
// Scoreboard bench for sparc_ctrl_seq: directed instruction sequences with per-cycle expected outputs.
// Define SPARC_CTRL_MFC_TIMEOUT_EN to exercise the F2 watchdog.
module tb_sparc_ctrl_seq;
  localparam int W = 48;

  localparam logic [4:0] RST1 = 5'd0,  RST2 = 5'd1,  RST3 = 5'd2,  F1  = 5'd3,
                         F2   = 5'd4,  F3   = 5'd5,  DEC  = 5'd6,  ALU = 5'd7,
                         N1   = 5'd8,  N2   = 5'd9,  BR   = 5'd10, BT1 = 5'd11,
                         BT2  = 5'd12, TRAP = 5'd13, T1   = 5'd14, T2  = 5'd15,
                         T3   = 5'd16, T4   = 5'd17, T5   = 5'd18, T6  = 5'd19,
                         ERRS = 5'd31;

  logic        clk = 1'b0;
  logic        Clr = 1'b0;
  logic [31:0] IR = 32'h0;
  logic        MFC = 1'b1;
  logic [3:0]  ICC = 4'h0;
  logic        ET = 1'b0;
  logic        TRAP_REQ = 1'b0;
  logic IRE, MDRE, MARE, PCE, nPCE, RFE, TBRE, PSRE, WIME, tQE;
  logic ClrPC, nPCClr, IRClr, tQClr;
  logic ALUE, MFA, nPC_ADD, nPC_ADDSEL, BAUX, MOP_SEL, PSR_SEL, RA_SEL, DISP_SEL, AOP_SEL;
  logic [1:0] nPC_SEL, MAR_SEL, MDR_SEL, ALU_SEL, CIN_SEL, RC_SEL;
  logic [5:0] OP1;
  logic       ERR;
  logic [4:0] STATE;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] dut_vec;
  int errors = 0;
  int checks = 0;
  int seq_idx = 0;

  sparc_ctrl_seq #(.MFC_TIMEOUT(15)) dut (
    .Clk(clk), .Clr(Clr), .IR(IR), .MFC(MFC), .ICC(ICC), .ET(ET), .TRAP_REQ(TRAP_REQ),
    .IRE(IRE), .MDRE(MDRE), .MARE(MARE), .PCE(PCE), .nPCE(nPCE), .RFE(RFE), .TBRE(TBRE),
    .PSRE(PSRE), .WIME(WIME), .tQE(tQE),
    .ClrPC(ClrPC), .nPCClr(nPCClr), .IRClr(IRClr), .tQClr(tQClr),
    .ALUE(ALUE), .MFA(MFA), .nPC_ADD(nPC_ADD), .nPC_ADDSEL(nPC_ADDSEL), .BAUX(BAUX),
    .MOP_SEL(MOP_SEL), .PSR_SEL(PSR_SEL), .RA_SEL(RA_SEL), .DISP_SEL(DISP_SEL), .AOP_SEL(AOP_SEL),
    .nPC_SEL(nPC_SEL), .MAR_SEL(MAR_SEL), .MDR_SEL(MDR_SEL), .ALU_SEL(ALU_SEL),
    .CIN_SEL(CIN_SEL), .RC_SEL(RC_SEL), .OP1(OP1), .ERR(ERR), .STATE(STATE)
  );

  always #5 clk = ~clk;

  assign dut_vec = {STATE, ERR, OP1,
                    IRE, MDRE, MARE, PCE, nPCE, RFE, TBRE, PSRE, WIME, tQE,
                    ClrPC, nPCClr, IRClr, tQClr,
                    ALUE, MFA, nPC_ADD, nPC_ADDSEL, BAUX, MOP_SEL, PSR_SEL, RA_SEL, DISP_SEL, AOP_SEL,
                    nPC_SEL, MAR_SEL, MDR_SEL, ALU_SEL, CIN_SEL, RC_SEL};

  // Expected output word for one state, built from the per-state control table.
  function automatic logic [W-1:0] exp_vec(input logic [4:0] st, input bit tt);
    logic ire, mdre, mare, pce, npce, rfe, tbre, psre, wime, tqe;
    logic clrpc, npcclr, irclr, tqclr;
    logic alue, mfa, npcadd, baux, mopsel, psrsel, err;
    logic [1:0] npcsel, marsel, cinsel, rcsel;
    {ire, mdre, mare, pce, npce, rfe, tbre, psre, wime, tqe} = 10'h3FF;
    {clrpc, npcclr, irclr, tqclr} = 4'hF;
    {alue, mfa, npcadd, baux, mopsel, psrsel, err} = 7'h00;
    {npcsel, marsel, cinsel, rcsel} = 8'h00;
    case (st)
      RST1: {clrpc, npcclr, irclr, tqclr} = 4'h0;
      RST2: {tbre, psre, wime, rfe} = 4'h0;
      RST3: begin npce = 0; npcadd = 1; end
      F1:   begin mare = 0; marsel = 2'd1; end
      F2:   begin mdre = 0; mfa = 1; mopsel = 1; end
      F3:   ire = 0;
      ALU:  begin rfe = 0; alue = 1; cinsel = 2'd2; end
      N1:   pce = 0;
      N2:   begin npce = 0; npcadd = 1; end
      BT1:  pce = 0;
      BT2:  begin npce = 0; baux = 1; npcsel = 2'd2; end
      TRAP: tqe = !tt;
      T1:   begin psre = 0; psrsel = 1; rfe = 0; rcsel = 2'd2; end
      T2:   begin rfe = 0; cinsel = 2'd1; rcsel = 2'd1; end
      T3:   tbre = 0;
      T4:   begin npce = 0; npcsel = 2'd1; end
      T5:   pce = 0;
      T6:   begin npce = 0; npcadd = 1; end
      ERRS: err = 1;
      default: ;
    endcase
    return {st, err, 6'h08,
            ire, mdre, mare, pce, npce, rfe, tbre, psre, wime, tqe,
            clrpc, npcclr, irclr, tqclr,
            alue, mfa, npcadd, 1'b0, baux, mopsel, psrsel, 1'b0, 1'b0, 1'b0,
            npcsel, marsel, 2'd0, 2'd0, cinsel, rcsel};
  endfunction

  // Monitor: every cycle with an expectation pending is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL seq_%0d exp_state=%0d got=%h exp=%h", seq_idx, e[W-1 -: 5], dut_vec, e);
      end
      seq_idx++;
    end
  end

  task automatic push(input logic [4:0] st, input bit tt = 1'b0);
    exp_q.push_back(exp_vec(st, tt));
  endtask

  task automatic step(input logic [4:0] st, input bit tt = 1'b0);
    @(posedge clk);
    #1;
    push(st, tt);
  endtask

  task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 Clr = 1'b0;
    @(posedge clk);
    #1 Clr = 1'b1;
    push(RST1);
    step(RST2);
    step(RST3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset sequence and first fetch
    MFC = 1'b1;
    do_reset();
    step(F1);

    // add: MFC late by three cycles, then ALU path
    IR = 32'hA2044012;
    MFC = 1'b0;
    step(F2); step(F2); step(F2); step(F2);
    MFC = 1'b1;
    step(F3); step(DEC); step(ALU); step(N1); step(N2); step(F1);

    // bpos,a not taken (N=1): delay slot annulled
    IR = 32'h3C800005;
    ICC = 4'b1000;
    step(F2); step(F3); step(DEC); step(BR);
    step(N1); step(N2); step(N1); step(N2); step(F1);

    // bpos,a taken (N=0): no annul
    ICC = 4'b0000;
    step(F2); step(F3); step(DEC); step(BR); step(BT1); step(BT2); step(F1);

    // Format-1 instruction goes straight to nPC update
    IR = 32'h40000001;
    step(F2); step(F3); step(DEC); step(N1); step(N2); step(F1);

    // te with Z=0: condition false, tQE stays inactive
    IR = 32'h83D02008;
    ICC = 4'b0000;
    step(F2); step(F3); step(DEC); step(TRAP, 1'b0); step(N1); step(N2); step(F1);

    // ta with ET=1 and a pending trap: full trap entry
    IR = 32'h91D02008;
    ET = 1'b1;
    step(F2); step(F3); step(DEC); step(TRAP, 1'b1); step(N1); step(N2);
    TRAP_REQ = 1'b1;
    step(T1);
    TRAP_REQ = 1'b0;
    step(T2); step(T3); step(T4); step(T5); step(T6); step(F1);

    // ta with ET=0 and a pending trap: error mode, held
    ET = 1'b0;
    step(F2); step(F3); step(DEC); step(TRAP, 1'b1); step(N1); step(N2);
    TRAP_REQ = 1'b1;
    step(ERRS);
    TRAP_REQ = 1'b0;
    step(ERRS); step(ERRS); step(ERRS);

    // MFC stuck low in F2
    MFC = 1'b0;
    do_reset();
    step(F1);
`ifdef SPARC_CTRL_MFC_TIMEOUT_EN
    repeat (15) step(F2);
    step(ERRS); step(ERRS);
    do_reset();
    step(F1);
    step(F2);
`else
    repeat (20) step(F2);
`endif

    // Asynchronous reset mid-F2 drops MFA without a clock edge
    @(posedge clk);
    #3;
    check_val("mfa_before_clr", {7'd0, MFA}, 8'd1);
    check_val("state_before_clr", {3'd0, STATE}, {3'd0, F2});
    Clr = 1'b0;
    #1;
    check_val("mfa_async_clr", {7'd0, MFA}, 8'd0);
    check_val("state_async_clr", {3'd0, STATE}, {3'd0, RST1});
    MFC = 1'b1;
    @(posedge clk);
    #1 Clr = 1'b1;
    push(RST1);
    step(RST2); step(RST3); step(F1);

    @(negedge clk);
    #1;
    check_val("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sparc_ctrl_seq.md
Name: sparc_ctrl_seq

Overview:
Moore control sequencer for the SPARC datapath (DataPathV5). It drives the datapath's active-low register enables, clears and mux selects through reset, fetch, decode, ALU-op, nPC-update, Bicc, Ticc and trap-entry sequences. It replaces hand-driven control in benches. Memory handshake is MFA/MFC with the datapath RAM.

Parameters:
MFC_TIMEOUT, 15, max cycles spent in F2 awaiting MFC (used only with the optional feature)

Ports:
Clk  in  1  clock, rising edge
Clr  in  1  asynchronous active-low reset
IR  in  32  instruction register contents
MFC  in  1  memory function complete
ICC  in  4  PSR[23:20] = N,Z,V,C
ET  in  1  PSR enable-traps bit
TRAP_REQ  in  1  trap queue non-empty
IRE,MDRE,MARE,PCE,nPCE,RFE,TBRE,PSRE,WIME,tQE  out  1 each  active-low load enables
ClrPC,nPCClr,IRClr,tQClr  out  1 each  active-low synchronous datapath clears
ALUE,MFA,nPC_ADD,nPC_ADDSEL,BAUX,MOP_SEL,PSR_SEL,RA_SEL,DISP_SEL,AOP_SEL  out  1 each  selects/strobes
nPC_SEL,MAR_SEL,MDR_SEL,ALU_SEL,CIN_SEL,RC_SEL  out  2 each  mux selects
OP1  out  6  memory op (6'h08 = word read)
ERR  out  1  error mode, high in ERR state
STATE  out  5  current state encoding (debug)

Behaviour:
- Outputs are decoded from the state register only (Moore). Default per state: all enables=1, clears=1, strobes=0, selects=0, OP1=6'h08; listed values override.
- Clr=0 forces state RST1 asynchronously; this aborts any sequence, including F2 with MFA high. MFA drops immediately.
- States and encodings:
  - RST1 (0): ClrPC, nPCClr, IRClr, tQClr = 0. -> RST2.
  - RST2 (1): TBRE, PSRE, WIME, RFE = 0. -> RST3.
  - RST3 (2): nPCE=0, nPC_ADD=1; nPC becomes 4. -> F1.
  - F1 (3): MARE=0, MAR_SEL=1 (MAR<-PC). -> F2.
  - F2 (4): MDRE=0, MFA=1, MOP_SEL=1, MDR_SEL=0. Stays in F2 while MFC=0; -> F3 on MFC=1.
  - F3 (5): IRE=0. -> DEC.
  - DEC (6): no outputs. Decodes IR in this order:
    - IR[31:30]=2 and IR[24:19]=6'h3A (Ticc) -> TRAP.
    - IR[31:30]=0 and IR[24:22]=3'b010 (Bicc) -> BR.
    - IR[31:30]=2 (any other) -> ALU.
    - Otherwise -> N1.
  - ALU (7): RFE=0, ALUE=1, CIN_SEL=2. -> N1.
  - N1 (8): PCE=0 (PC<-nPC). -> N2.
  - N2 (9): nPCE=0, nPC_ADD=1. If TRAP_REQ=1 and ET=1 -> T1. If TRAP_REQ=1 and ET=0 -> ERR. Else -> F1 (or -> N1 if the annul flag is set; the flag clears there).
  - BR (10): evaluates cond=IR[28:25] per the SPARC V8 icc table (0000 never, 1000 always, 0001 Z, 1001 !Z, 0101 C, 1101 !C, 0110 N, 1110 !N, 0111 V, 1111 !V, 0011 N^V, 1011 !(N^V), 0010 Z|(N^V), 1010 !(Z|(N^V)), 0100 C|Z, 1100 !(C|Z)).
    - Sets annul flag = IR[29] & (!taken | cond==1000).
    - Taken -> BT1; not taken -> N1.
  - BT1 (11): PCE=0. -> BT2.
  - BT2 (12): nPCE=0, BAUX=1, nPC_SEL=2, DISP_SEL=0 (nPC<-PC+disp22*4). -> F1, or -> N1 if annul.
  - TRAP (13): condition evaluated as in BR. True: tQE=0 is asserted in this state only when true (registered at DEC->TRAP). -> N1.
  - T1 (14): PSRE=0, PSR_SEL=1, RFE=0, CIN_SEL=0, RC_SEL=2 (r17<-PC). -> T2.
  - T2 (15): RFE=0, CIN_SEL=1, RC_SEL=1 (r18<-nPC). -> T3.
  - T3 (16): TBRE=0. -> T4.
  - T4 (17): nPCE=0, nPC_SEL=1 (nPC<-TBR). -> T5.
  - T5 (18): PCE=0. -> T6.
  - T6 (19): nPCE=0, nPC_ADD=1. -> F1. TRAP_REQ is not rechecked until the next N2.
  - ERR (31): ERR=1, all enables inactive; held until Clr.
- Latencies:
  - Non-branch, non-trap instruction: F1 to next F1 is 6 cycles plus MFC wait cycles (7 for ALU).
  - Taken branch without annul: 7 cycles.
- Unused encodings -> ERR.

Optional Feature:
SPARC_CTRL_MFC_TIMEOUT_EN:
- Defined: a 4-bit-minimum counter runs in F2 and clears on F2 entry. If MFC is still 0 after MFC_TIMEOUT cycles, -> ERR with MFA deasserted.
- Undefined: F2 waits indefinitely; no counter logic.

Test Plan:
- Clr pulse low, MFC tied 1 -> RST1/2/3 then F1. In RST1 all four clears=0; in RST3 nPCE=0 and nPC_ADD=1; STATE sequence 0,1,2,3.
- Fetch IR=32'hA2044012 (add), MFC delayed 3 cycles -> F2 held 4 cycles with MFA=1; F3 IRE=0; then ALU state with RFE=0, ALUE=1; then N1, N2, F1.
- IR=32'h3C800005 (bpos,a) with ICC=4'b1000 -> not taken, annul set -> N1,N2,N1,N2,F1 (PC/nPC advance twice).
- Same IR with ICC=0 -> BR, BT1, BT2 with nPC_SEL=2, BAUX=1, DISP_SEL=0; then F1.
- Ticc always (IR=32'h91D02008) with ET=1, TRAP_REQ rising in N2 -> TRAP asserts tQE=0; then T1..T6 with listed selects; then F1. Same with ET=0 -> ERR=1, held until Clr.
- Clr asserted mid-F2 with MFA=1 -> MFA=0 and STATE=0 immediately, without waiting for a clock edge; with SPARC_CTRL_MFC_TIMEOUT_EN and MFC stuck 0 -> ERR after 15 cycles in F2.
